dm_arb: RTL

Two-port arbiter and sequencer for the 128-word data memory (dm). It shares the single dm access port between port 0 (CPU load/store stage) and port 1 (loader/debug port) using round-robin arbitration. It drives dm's addr/rd/wr/wdata from registers, captures dm rdata, and returns a one-cycle ack to the served requester. Sits between the MEM pipeline stage and dm; dm is unchanged.

---
 rtl/dm_arb_if.sv | 54 +++++
 rtl/dm_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dm_arb_if.sv
// Bundle of the two requester ports and the data-memory access port served by dm_arb.
// The slave modport is the arbiter's view; the master modport is the view of the
// environment that drives the requesters and provides the memory.
interface dm_arb_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    // port 0 (CPU load/store stage)
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    // port 1 (loader/debug port)
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    // data memory side
    logic [AW-1:0] m_addr;
    logic          m_rd;
    logic          m_wr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_ack, p1_rdata,
        output m_addr, m_rd, m_wr, m_wdata,
        input  m_rdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_ack, p1_rdata,
        input  m_addr, m_rd, m_wr, m_wdata,
        output m_rdata,
        input  busy
    );
endinterface

// File: rtl/dm_arb.sv
// Two-port round-robin arbiter/sequencer for the single data-memory port.
// Each access is IDLE -> ACCESS (one cycle, strobe + gnt) -> DONE (one cycle, ack).
// From DONE the other port can be served directly, so alternating ports get one
// access every two cycles; the port just acknowledged is ignored in DONE so a
// requester that drops req on ack is never served twice.
module dm_arb #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic    clk,
    input  logic    reset,
    dm_arb_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          last_r, last_s;     // port served most recently
    logic          sel_r, sel_s;       // port owning the current access
    logic [AW-1:0] addr_r, addr_s;
    logic [DW-1:0] wdata_r, wdata_s;
    logic          rd_r, rd_s;
    logic          wr_r, wr_s;
    logic [1:0]    gnt_r, gnt_s;
    logic [1:0]    ack_r, ack_s;
    logic [DW-1:0] rdata0_r, rdata0_s;
    logic [DW-1:0] rdata1_r, rdata1_s;
    logic          busy_r, busy_s;

    logic [1:0]    elig_s;             // ports eligible to be served this cycle
    logic          pick_s;             // winning port among the eligible ones
    logic          pick_we_s;

    assign bus.m_addr   = addr_r;
    assign bus.m_wdata  = wdata_r;
    assign bus.m_rd     = rd_r;
    assign bus.m_wr     = wr_r;
    assign bus.p0_gnt   = gnt_r[0];
    assign bus.p1_gnt   = gnt_r[1];
    assign bus.p0_ack   = ack_r[0];
    assign bus.p1_ack   = ack_r[1];
    assign bus.p0_rdata = rdata0_r;
    assign bus.p1_rdata = rdata1_r;
    assign bus.busy     = busy_r;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        sel_s     = sel_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        gnt_s     = 2'b00;
        ack_s     = 2'b00;
        rdata0_s  = rdata0_r;
        rdata1_s  = rdata1_r;

        case (state_r)
            ST_IDLE: elig_s = {bus.p1_req, bus.p0_req};
            ST_DONE: elig_s = {bus.p1_req & ~sel_r, bus.p0_req & sel_r};
            default: elig_s = 2'b00;
        endcase

        if (elig_s == 2'b11) begin
            pick_s = ~last_r;
        end else begin
            pick_s = elig_s[1];
        end
        pick_we_s = pick_s ? bus.p1_we : bus.p0_we;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (elig_s != 2'b00) begin
                    addr_s  = pick_s ? bus.p1_addr : bus.p0_addr;
                    wdata_s = pick_s ? bus.p1_wdata : bus.p0_wdata;
                    wr_s    = pick_we_s;
                    rd_s    = ~pick_we_s;
                    gnt_s   = pick_s ? 2'b10 : 2'b01;
                    last_s  = pick_s;
                    sel_s   = pick_s;
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // memory read data is valid during ACCESS; capture it for the owner
                if (rd_r) begin
                    if (sel_r) begin
                        rdata1_s = bus.m_rdata;
                    end else begin
                        rdata0_s = bus.m_rdata;
                    end
                end else begin
                    rdata0_s = rdata0_r;
                end
                ack_s   = sel_r ? 2'b10 : 2'b01;
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;
            sel_r    <= 1'b0;
            addr_r   <= {AW{1'b0}};
            wdata_r  <= {DW{1'b0}};
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            gnt_r    <= 2'b00;
            ack_r    <= 2'b00;
            rdata0_r <= {DW{1'b0}};
            rdata1_r <= {DW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            last_r   <= last_s;
            sel_r    <= sel_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            rd_r     <= rd_s;
            wr_r     <= wr_s;
            gnt_r    <= gnt_s;
            ack_r    <= ack_s;
            rdata0_r <= rdata0_s;
            rdata1_r <= rdata1_s;
            busy_r   <= busy_s;
        end
    end

endmodule
